oled_glyph_sequencer: RTL

Sits directly upstream of the OLED glyph driver. It accepts glyph-select requests from game logic and queues them in a small FIFO. For each request it produces the data/dataReady strobe the driver expects: data stable before, during and after the falling edge of dataReady, because the driver latches on that edge. It then waits for the driver to finish a full refresh before issuing the next request.

---
 rtl/oled_pkg.sv | 22 ++
 rtl/oled_glyph_sequencer_if.sv | 25 ++
 rtl/glyph_req_fifo.sv | 61 ++++++
 rtl/oled_glyph_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared glyph constants and sequencer state encoding
package oled_pkg;

    localparam int GLYPH_W   = 16;
    localparam int MAX_GLYPH = 27;
    localparam logic [GLYPH_W-1:0] BLANK_GLYPH = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT_DONE
    } seq_state_t;

    // Out-of-range glyph indices render as the blank glyph.
    function automatic logic [GLYPH_W-1:0] clamp_glyph(input logic [GLYPH_W-1:0] glyph,
                                                       input int max_glyph);
        return ({16'd0, glyph} > $unsigned(max_glyph)) ? BLANK_GLYPH : glyph;
    endfunction

endpackage

// File: rtl/oled_glyph_sequencer_if.sv
// rtl/oled_glyph_sequencer_if.sv - request and driver-side signals of the glyph sequencer
interface oled_glyph_sequencer_if;
    import oled_pkg::*;

    logic [GLYPH_W-1:0] req_glyph;
    logic               req_valid;
    logic               req_ready;
    logic               oled_idle;
    logic [GLYPH_W-1:0] data;
    logic               dataReady;
    logic               busy;
    logic               dropped;
    logic               timeout_err;

    modport master (
        output req_glyph, req_valid, oled_idle,
        input  req_ready, data, dataReady, busy, dropped, timeout_err
    );

    modport slave (
        input  req_glyph, req_valid, oled_idle,
        output req_ready, data, dataReady, busy, dropped, timeout_err
    );

endinterface

// File: rtl/glyph_req_fifo.sv
// rtl/glyph_req_fifo.sv - synchronous request FIFO with count and same-cycle push/pop
module glyph_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO may still push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/oled_glyph_sequencer.sv
// rtl/oled_glyph_sequencer.sv - queues glyph requests and strobes them into the OLED driver
module oled_glyph_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_GLYPH      = oled_pkg::MAX_GLYPH,
    parameter int SETUP_CYCLES   = 4,
    parameter int PULSE_CYCLES   = 1000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    oled_glyph_sequencer_if.slave  bus
);
    import oled_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = (SETUP_CYCLES > 1)   ? $clog2(SETUP_CYCLES)   : 1;
    localparam int PW = (PULSE_CYCLES > 1)   ? $clog2(PULSE_CYCLES)   : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SW-1:0] SETUP_LAST   = SW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q;
    logic [GLYPH_W-1:0] last_glyph_q;
    logic [GLYPH_W-1:0] last_enq_q;
    logic               data_ready_q;
    logic               started_q;
    logic               dropped_q;
    logic               timeout_err_q;
    logic [SW-1:0]      setup_cnt_q;
    logic [PW-1:0]      pulse_cnt_q;
    logic [TW-1:0]      tmo_cnt_q;

    logic [GLYPH_W-1:0] clamped;
    logic [GLYPH_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               busy;
    logic               dup;
    logic               pop;
    logic               push;
    logic               drop;
    logic               started_now;

    assign busy    = (state_q != ST_IDLE);
    assign clamped = clamp_glyph(bus.req_glyph, MAX_GLYPH);
    assign pop     = (state_q == ST_IDLE) && !fifo_empty && bus.oled_idle;

    // Repeats of the value already queued last, or already on screen when idle, are silently ignored.
    assign dup  = fifo_empty ? ((clamped == last_glyph_q) && !busy) : (clamped == last_enq_q);
    assign push = bus.req_valid && bus.req_ready && !dup;
    assign drop = bus.req_valid && fifo_full && !pop && !dup;
    assign started_now = started_q || !bus.oled_idle;

    glyph_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (GLYPH_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (clamped),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_glyph_q  <= BLANK_GLYPH;
            last_enq_q    <= BLANK_GLYPH;
            data_ready_q  <= 1'b0;
            started_q     <= 1'b0;
            dropped_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            setup_cnt_q   <= '0;
            pulse_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            dropped_q     <= drop;
            if (push) begin
                last_enq_q <= clamped;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q      <= ST_SETUP;
                        last_glyph_q <= fifo_head;
                        setup_cnt_q  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        state_q      <= ST_PULSE;
                        data_ready_q <= 1'b1;
                        pulse_cnt_q  <= '0;
                        started_q    <= 1'b0;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 1'b1;
                    end
                end
                ST_PULSE: begin
                    started_q <= started_now;
                    if (pulse_cnt_q == PULSE_LAST) begin
                        data_ready_q <= 1'b0;
                        tmo_cnt_q    <= '0;
                        state_q      <= started_now ? ST_WAIT_DONE : ST_HOLD;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!bus.oled_idle) begin
                        state_q   <= ST_WAIT_DONE;
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                        state_q       <= ST_IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.oled_idle) begin
                        state_q <= ST_IDLE;
                    end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                        state_q       <= ST_IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (fifo_count < CW'(FIFO_DEPTH)) || pop;
    assign bus.data        = last_glyph_q;
    assign bus.dataReady   = data_ready_q;
    assign bus.busy        = busy;
    assign bus.dropped     = dropped_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
